if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the ID-stage decoder.
//  Holds the PC, runs a single-outstanding request/response handshake to instruction memory,
//  and presents {instr, pc, pc+4, valid} to ID. Instr bits [31:26] drive the decoder's op input.
//  Honours ID-stage stall (hold) and branch/jump redirect (flush).
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC fetched first after reset
//  AW        32             PC/address width
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  imem_req       out  1   fetch request, 1-cycle pulse per fetch
//  imem_addr      out  AW  word address of fetch (pc, low 2 bits 0)
//  imem_rdata     in   32  fetched instruction
//  imem_rvalid    in   1   imem_rdata valid; >=1 cycle after imem_req
//  stall          in   1   1 = hold IF/ID contents, no PC advance
//  redirect       in   1   1 = branch taken / jump in ID; flush and refetch
//  redirect_pc    in   AW  new PC on redirect
//  id_instr       out  32  IF/ID instruction (32'h0 = nop when invalid)
//  id_op          out  6   id_instr[31:26], to decoder
//  id_pc          out  AW  PC of id_instr
//  id_pc_plus4    out  AW  id_pc + 4 (JAL link value)
//  id_valid       out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, state=REQ, kill=0, skid empty; id_instr=0, id_pc=0,
//   id_pc_plus4=0, id_valid=0. imem_req=0 while rst=1. First imem_req the cycle after rst drops.
//  States: REQ, WAIT, HOLD.
//   REQ : imem_req=1, imem_addr=pc -> WAIT.
//   WAIT: await imem_rvalid. On rvalid with kill=1: drop data, kill<=0 -> REQ.
//         On rvalid, kill=0, stall=0: IF/ID<= {rdata, pc, pc+4, valid=1}; pc<=pc+4 -> REQ.
//         On rvalid, kill=0, stall=1: rdata into skid buffer -> HOLD.
//   HOLD: imem_req=0. When stall=0: IF/ID<=skid, pc<=pc+4 -> REQ.
//  IF/ID loads every cycle stall=0: new instr if delivered this cycle, else bubble (instr=0, valid=0).
//  stall=1: IF/ID, pc unchanged; outstanding fetch still completes (into skid).
//  Redirect (priority over stall): at posedge with redirect=1: pc<=redirect_pc & ~3, IF/ID<=bubble,
//   skid cleared. State REQ/HOLD -> REQ. State WAIT: rvalid same cycle is discarded -> REQ;
//   else kill<=1, stay WAIT (stale response dropped, then REQ at new pc).
//  Min fetch throughput: 1 instr / 2 cycles at 1-cycle memory latency.
//  pc+4 wraps modulo 2^AW. imem_rdata never enters IF/ID when kill=1 or redirect=1.
//  rst mid-fetch: outstanding response ignored (state REQ, kill=0); memory must tolerate abandon.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_stall_cyc [31:0] (+1 each cycle stall=1 & ~redirect)
//   and perf_flush_cnt [31:0] (+1 each cycle redirect=1); both wrap, reset to 0 by rst.
//  IF_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset release, mem latency 1, no stall -> imem_addr 0x3000,0x3004,0x3008; id_valid every 2nd cycle, id_pc matches.
//  rdata=32'h8C08_0004 (lw) -> id_op=6'b100011, id_pc_plus4=id_pc+4.
//  stall=1 for 3 cycles during WAIT -> IF/ID held, one response captured in skid, no new imem_req;
//   release -> skid instr appears next cycle, pc advances once.
//  redirect=1, redirect_pc=0x3102 while WAIT (latency 3) -> stale rdata dropped, next imem_addr=0x3100,
//   id_valid=0 cycle after redirect.
//  redirect=1 and stall=1 same cycle -> flush wins: id_valid=0, next fetch at redirect target.
//  pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000; with IF_PERF_CNT_EN, 5 stall cycles + 2 redirects
//   -> perf_stall_cyc=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/if_fetch_stage.sv
// IF stage: PC, single-outstanding imem fetch (REQ/WAIT/HOLD), IF/ID register; >=2 cycles/instr, stall holds IF/ID and parks a late response in a skid.
// Define IF_PERF_CNT_EN to add perf_stall_cyc / perf_flush_cnt counters.
module if_fetch_stage #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_rvalid,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [31:0]   id_instr,
    output logic [5:0]    id_op,
    output logic [AW-1:0] id_pc,
    output logic [AW-1:0] id_pc_plus4,
    output logic          id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]   perf_stall_cyc,
    output logic [31:0]   perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic          r_kill;
    logic [31:0]   r_skid;
    logic [31:0]   r_id_instr;
    logic [AW-1:0] r_id_pc;
    logic [AW-1:0] r_id_pc4;
    logic          r_id_valid;

    logic [AW-1:0] w_pc4;
    logic          w_deliver;
    logic          w_resp;

    assign w_pc4     = r_pc + AW'(4);
    assign w_resp    = (r_state == S_WAIT) && imem_rvalid;
    assign w_deliver = w_resp && !r_kill && !redirect && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_REQ:   w_state_nxt = redirect ? S_REQ : S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = (redirect || r_kill || !stall) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // A redirect in REQ suppresses the request so no response to the old PC is ever in flight.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = {r_pc[AW-1:2], 2'b00};
        if (r_state == S_REQ && !rst && !redirect) begin
            imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_skid     <= 32'h0;
            r_id_instr <= 32'h0;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
        end else if (redirect) begin
            r_pc       <= {redirect_pc[AW-1:2], 2'b00};
            r_kill     <= (r_state == S_WAIT) && !imem_rvalid;
            r_skid     <= 32'h0;
            r_id_instr <= 32'h0;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
        end else begin
            if (w_resp) begin
                r_kill <= 1'b0;
                if (!r_kill && stall) begin
                    r_skid <= imem_rdata;
                end
            end
            if (!stall) begin
                if (w_deliver) begin
                    r_id_instr <= imem_rdata;
                    r_id_pc    <= r_pc;
                    r_id_pc4   <= w_pc4;
                    r_id_valid <= 1'b1;
                    r_pc       <= w_pc4;
                end else if (r_state == S_HOLD) begin
                    r_id_instr <= r_skid;
                    r_id_pc    <= r_pc;
                    r_id_pc4   <= w_pc4;
                    r_id_valid <= 1'b1;
                    r_pc       <= w_pc4;
                end else begin
                    r_id_instr <= 32'h0;
                    r_id_pc    <= '0;
                    r_id_pc4   <= '0;
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    assign id_instr    = r_id_instr;
    assign id_op       = r_id_instr[31:26];
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc4;
    assign id_valid    = r_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (stall && !redirect) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded random bench for if_fetch_stage: driver/memory model predicts IF/ID per cycle, monitor compares.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          NCYC     = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_stage #(.AW(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_instr(id_instr), .id_op(id_op), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
`ifdef IF_PERF_CNT_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // kind: 0 reset, 1 bubble, 2 hold previous, 3 instruction
    typedef struct {
        int          kind;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   items  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Driver, instruction memory and reference model.
    initial begin
        exp_t        e;
        exp_t        pend_q[$];
        logic [31:0] fetch_pc, sc, fc;
        logic [31:0] out_addr, resp_addr, resp_data;
        int          out_wait, out_gen, resp_gen, gen, idle, lat, nreq;
        bit          out_vld, resp_now, consumed;

        fetch_pc = RESET_PC; sc = 0; fc = 0;
        out_addr = 0; resp_addr = 0; resp_data = 0;
        out_wait = 0; out_gen = 0; resp_gen = 0; gen = 0; idle = 0; lat = 1; nreq = 0;
        out_vld = 0; resp_now = 0; consumed = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst         = (cyc < 3) || (cyc == 80) || (cyc == 81);
            stall       = 1'b0;
            redirect    = 1'b0;
            redirect_pc = $urandom;
            lat         = (cyc < 25 || (cyc >= 60 && cyc < 80)) ? 1 : 3;
            if (cyc >= 27 && cyc <= 29) stall = 1'b1;
            if (cyc == 45) begin redirect = 1'b1; redirect_pc = 32'h0000_3102; end
            if (cyc == 55) begin redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_4000; end
            if (cyc == 60) begin redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4; end
            if (cyc >= 90) begin
                lat      = $urandom_range(1, 3);
                rst      = ($urandom_range(0, 299) == 0);
                stall    = ($urandom_range(0, 3) == 0);
                redirect = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end

            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            resp_now    = 0;
            if (rst) begin
                out_vld = 0;
            end else if (out_vld) begin
                out_wait--;
                if (out_wait == 0) begin
                    resp_data   = (cyc < 25) ? 32'h8C08_0004 : $urandom;
                    imem_rvalid = 1'b1;
                    imem_rdata  = resp_data;
                    resp_now    = 1;
                    resp_addr   = out_addr;
                    resp_gen    = out_gen;
                    out_vld     = 0;
                end
            end
            #1;

            e.kind = 1; e.instr = 32'h0; e.pc = 32'h0;
            if (rst) begin
                chk("req_during_reset", 32'(imem_req), 32'd0);
                pend_q.delete();
                fetch_pc = RESET_PC; gen++; idle = 0; sc = 0; fc = 0;
                e.kind = 0;
            end else begin
                if (imem_req) begin
                    nreq++;
                    chk("fetch_addr", imem_addr, fetch_pc);
                    chk("req_while_busy", 32'(out_vld || pend_q.size() != 0), 32'd0);
                    out_vld = 1; out_wait = lat; out_addr = imem_addr; out_gen = gen; idle = 0;
                end else if (!out_vld && pend_q.size() == 0 && !resp_now && !redirect) begin
                    idle++;
                    if (idle > 3) begin
                        chk("idle_cycles_without_req", 32'(idle), 32'd3);
                        idle = 0;
                    end
                end
                consumed = resp_now && !redirect && (resp_gen == gen);
                if (consumed) begin
                    exp_t it;
                    it.kind = 3; it.instr = resp_data; it.pc = resp_addr; it.sc = 0; it.fc = 0;
                    pend_q.push_back(it);
                    fetch_pc = resp_addr + 32'd4;
                end
                if (stall && !redirect) sc++;
                if (redirect) fc++;
                if (redirect) begin
                    pend_q.delete();
                    fetch_pc = {redirect_pc[31:2], 2'b00};
                    gen++;
                    e.kind = 1;
                end else if (stall) begin
                    e.kind = 2;
                end else if (pend_q.size() != 0) begin
                    e = pend_q.pop_front();
                end
            end
            e.sc = sc; e.fc = fc;
            exp_q.push_back(e);
        end

        @(posedge clk);
        #3;
        if (nreq < 150) chk("too_few_fetch_requests", 32'(nreq), 32'd150);
        if (items < 100) chk("too_few_delivered_instrs", 32'(items), 32'd100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t        m;
        logic [31:0] p_instr, p_pc, p_pc4;
        logic        p_valid;
        p_instr = 0; p_pc = 0; p_pc4 = 0; p_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                m = exp_q.pop_front();
                case (m.kind)
                    0: begin
                        chk("reset_valid", 32'(id_valid), 32'd0);
                        chk("reset_instr", id_instr, 32'h0);
                        chk("reset_pc", id_pc, 32'h0);
                        chk("reset_pc_plus4", id_pc_plus4, 32'h0);
                    end
                    1: begin
                        chk("bubble_valid", 32'(id_valid), 32'd0);
                        chk("bubble_instr", id_instr, 32'h0);
                    end
                    2: begin
                        chk("stall_hold_valid", 32'(id_valid), 32'(p_valid));
                        chk("stall_hold_instr", id_instr, p_instr);
                        chk("stall_hold_pc", id_pc, p_pc);
                        chk("stall_hold_pc_plus4", id_pc_plus4, p_pc4);
                    end
                    default: begin
                        items++;
                        chk("instr_valid", 32'(id_valid), 32'd1);
                        chk("instr_data", id_instr, m.instr);
                        chk("instr_op", 32'(id_op), 32'(m.instr[31:26]));
                        chk("instr_pc", id_pc, m.pc);
                        chk("instr_pc_plus4", id_pc_plus4, m.pc + 32'd4);
                    end
                endcase
`ifdef IF_PERF_CNT_EN
                chk("perf_stall_cyc", perf_stall_cyc, m.sc);
                chk("perf_flush_cnt", perf_flush_cnt, m.fc);
`endif
            end
            p_instr = id_instr; p_pc = id_pc; p_pc4 = id_pc_plus4; p_valid = id_valid;
        end
    end
endmodule
